id_ex_stage_buf: RTL and testbench

Parametrised ID→EX pipeline stage buffer for the 16-bit MISC-V core. It carries decoded control bits and operand/register fields from decode to execute through a two-entry skid buffer with valid/ready handshakes. The buffer provides synchronous flush for branch squash and a saturating back-pressure stall counter. Bubbles always present all-zero control, so execute sees a NOP.

---
 rtl/id_ex_stage_buf.sv | 176 +++++++++++++++++
 tb/tb_id_ex_stage_buf.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_buf.sv
// ID->EX stage buffer: two-entry skid buffer (main head + skid) carrying decoded
// control and operand fields, with flush and a saturating back-pressure counter.
module id_ex_stage_buf #(
  parameter int DATA_W  = 16,
  parameter int NUM_OPS = 7,
  parameter int CTRL_W  = 9,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [NUM_OPS*DATA_W-1:0] in_ops,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [NUM_OPS*DATA_W-1:0] out_ops,
  output logic [1:0]                occupancy,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int OPS_W = NUM_OPS * DATA_W;

  // ST_MAIN: head only; ST_FULL: head and skid both hold an entry.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CTRL_W-1:0]  r_main_ctrl;
  logic [OPS_W-1:0]   r_main_ops;
  logic [CTRL_W-1:0]  r_skid_ctrl;
  logic [OPS_W-1:0]   r_skid_ops;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic w_accept;
  logic w_drain;
  logic w_load_main;
  logic w_load_skid;
  logic w_skid_to_main;

  assign w_accept = in_valid & in_ready;
  assign w_drain  = out_valid & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush squashes both entries, including a same-cycle accept
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) w_state_nxt = ST_MAIN;
        else          w_state_nxt = ST_EMPTY;
      end
      ST_MAIN: begin
        if (w_drain) w_state_nxt = w_accept ? ST_MAIN : ST_EMPTY;
        else         w_state_nxt = w_accept ? ST_FULL : ST_MAIN;
      end
      ST_FULL: begin
        if (w_drain) w_state_nxt = ST_MAIN;
        else         w_state_nxt = ST_FULL;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // Handshake, occupancy and NOP-gated control, all from registers only
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b1;
    occupancy = 2'd0;
    case (r_state)
      ST_EMPTY: begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        occupancy = 2'd0;
      end
      ST_MAIN: begin
        out_valid = 1'b1;
        in_ready  = 1'b1;
        occupancy = 2'd1;
      end
      ST_FULL: begin
        out_valid = 1'b1;
        in_ready  = 1'b0;
        occupancy = 2'd2;
      end
      default: begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        occupancy = 2'd0;
      end
    endcase
    if (out_valid) begin
      out_ctrl = r_main_ctrl;
    end else begin
      out_ctrl = {CTRL_W{1'b0}};
    end
  end

  assign out_ops   = r_main_ops;
  assign stall_cnt = r_stall_cnt;

  // Datapath steering derived from the pre-edge state
  always_comb begin
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    case (r_state)
      ST_EMPTY: w_load_main = w_accept;
      ST_MAIN: begin
        w_load_main = w_accept & w_drain;
        w_load_skid = w_accept & ~w_drain;
      end
      ST_FULL:  w_skid_to_main = w_drain;
      default: begin
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
      end
    endcase
  end

  // Entry payload registers; flush clears control but keeps operands visible
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_ctrl <= {CTRL_W{1'b0}};
      r_main_ops  <= {OPS_W{1'b0}};
      r_skid_ctrl <= {CTRL_W{1'b0}};
      r_skid_ops  <= {OPS_W{1'b0}};
    end else if (flush) begin
      r_main_ctrl <= {CTRL_W{1'b0}};
      r_skid_ctrl <= {CTRL_W{1'b0}};
    end else begin
      if (w_load_main) begin
        r_main_ctrl <= in_ctrl;
        r_main_ops  <= in_ops;
      end else if (w_skid_to_main) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_ops  <= r_skid_ops;
        r_skid_ctrl <= {CTRL_W{1'b0}};
      end
      if (w_load_skid) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_ops  <= in_ops;
      end
    end
  end

  // Back-pressure counter: saturates, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_id_ex_stage_buf.sv
// Bench for id_ex_stage_buf: directed vector table, saturation/reset sequences,
// and randomized traffic against a queue-based reference model.
module tb_id_ex_stage_buf;

  localparam int OW = 112;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, in_valid, flush, out_ready;
  logic [8:0]    in_ctrl;
  logic [OW-1:0] in_ops;
  logic          in_ready, out_valid;
  logic [8:0]    out_ctrl;
  logic [OW-1:0] out_ops;
  logic [1:0]    occupancy;
  logic [7:0]    stall_cnt;
  logic          d4_in_ready, d4_out_valid;
  logic [8:0]    d4_out_ctrl;
  logic [OW-1:0] d4_out_ops;
  logic [1:0]    d4_occupancy;
  logic [3:0]    d4_stall_cnt;

  id_ex_stage_buf dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_ops(in_ops), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_ops(out_ops),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  id_ex_stage_buf #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d4_in_ready),
    .in_ctrl(in_ctrl), .in_ops(in_ops), .flush(flush), .out_valid(d4_out_valid),
    .out_ready(out_ready), .out_ctrl(d4_out_ctrl), .out_ops(d4_out_ops),
    .occupancy(d4_occupancy), .stall_cnt(d4_stall_cnt)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Rd in field 6, its complement in field 0
  function automatic logic [OW-1:0] mkops(input logic [15:0] rd);
    mkops = {rd, 80'h0, ~rd};
  endfunction

  // Reference model: an in-order queue of at most two entries
  typedef struct packed {
    logic [8:0]    c;
    logic [OW-1:0] o;
  } ent_t;
  ent_t          q[$];
  logic [OW-1:0] m_shown;
  int            m_cnt;

  task automatic model_step();
    bit acc, drn;
    ent_t e;
    if (reset) begin
      q.delete();
      m_shown = '0;
      m_cnt   = 0;
    end else begin
      if (q.size() > 0 && !out_ready) m_cnt++;
      acc = in_valid && (q.size() < 2);
      drn = (q.size() > 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) begin
          e.c = in_ctrl;
          e.o = in_ops;
          q.push_back(e);
        end
        if (q.size() > 0) m_shown = q[0].o;
      end
    end
  endtask

  task automatic model_check();
    logic       ev;
    logic [8:0] ec;
    ev = (q.size() > 0);
    ec = ev ? q[0].c : 9'h000;
    chk("rnd_out_valid", {127'h0, out_valid}, {127'h0, ev});
    chk("rnd_out_ctrl", {119'h0, out_ctrl}, {119'h0, ec});
    chk("rnd_out_ops", {16'h0, out_ops}, {16'h0, m_shown});
    chk("rnd_occupancy", {126'h0, occupancy}, 128'(q.size()));
    chk("rnd_in_ready", {127'h0, in_ready}, {127'h0, (q.size() < 2)});
    chk("rnd_stall8", {120'h0, stall_cnt}, 128'((m_cnt > 255) ? 255 : m_cnt));
    chk("rnd_stall4", {124'h0, d4_stall_cnt}, 128'((m_cnt > 15) ? 15 : m_cnt));
    chk("rnd4_out_valid", {127'h0, d4_out_valid}, {127'h0, ev});
    chk("rnd4_out_ctrl", {119'h0, d4_out_ctrl}, {119'h0, ec});
    chk("rnd4_out_ops", {16'h0, d4_out_ops}, {16'h0, m_shown});
    chk("rnd4_occ_rdy", {125'h0, d4_occupancy, d4_in_ready},
        {125'h0, 2'(q.size()), (q.size() < 2)});
  endtask

  // Apply inputs at the falling edge, clock them in, sample at the next falling edge
  task automatic drive(input logic rst, input logic v, input logic [8:0] c,
                       input logic [OW-1:0] ops, input logic ordy, input logic fl);
    reset     = rst;
    in_valid  = v;
    in_ctrl   = c;
    in_ops    = ops;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic rst, v; logic [8:0] c; logic [15:0] rd; logic ordy, fl;
    logic ev; logic [8:0] ec; logic [15:0] erd; logic [1:0] eocc; logic eir; logic [7:0] est;
  } vec_t;
  vec_t tbl[22];

  function automatic vec_t mk(input logic rst, v, input logic [8:0] c, input logic [15:0] rd,
                              input logic ordy, fl, ev, input logic [8:0] ec,
                              input logic [15:0] erd, input logic [1:0] eocc,
                              input logic eir, input logic [7:0] est);
    vec_t t;
    t.rst = rst; t.v = v; t.c = c; t.rd = rd; t.ordy = ordy; t.fl = fl;
    t.ev = ev; t.ec = ec; t.erd = erd; t.eocc = eocc; t.eir = eir; t.est = est;
    return t;
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_ctrl = 9'h000; in_ops = '0;
    out_ready = 1'b0; flush = 1'b0;
    q.delete(); m_shown = '0; m_cnt = 0;

    //                rst  v     ctrl    rd      ordy  fl  | ev   ectrl   erd     occ   ir    stall
    tbl[0]  = mk(1'b1, 1'b0, 9'h000, 16'h00, 1'b1, 1'b0, 1'b0, 9'h000, 16'h00, 2'd0, 1'b1, 8'd0);
    tbl[1]  = mk(1'b0, 1'b1, 9'h1FF, 16'h01, 1'b1, 1'b0, 1'b1, 9'h1FF, 16'h01, 2'd1, 1'b1, 8'd0);
    tbl[2]  = mk(1'b0, 1'b1, 9'h1FF, 16'h02, 1'b1, 1'b0, 1'b1, 9'h1FF, 16'h02, 2'd1, 1'b1, 8'd0);
    tbl[3]  = mk(1'b0, 1'b1, 9'h1FF, 16'h03, 1'b1, 1'b0, 1'b1, 9'h1FF, 16'h03, 2'd1, 1'b1, 8'd0);
    tbl[4]  = mk(1'b0, 1'b1, 9'h1FF, 16'h04, 1'b1, 1'b0, 1'b1, 9'h1FF, 16'h04, 2'd1, 1'b1, 8'd0);
    tbl[5]  = mk(1'b0, 1'b1, 9'h1FF, 16'h05, 1'b1, 1'b0, 1'b1, 9'h1FF, 16'h05, 2'd1, 1'b1, 8'd0);
    tbl[6]  = mk(1'b0, 1'b0, 9'h000, 16'h00, 1'b1, 1'b0, 1'b0, 9'h000, 16'h05, 2'd0, 1'b1, 8'd0);
    tbl[7]  = mk(1'b0, 1'b1, 9'h0AA, 16'hA1, 1'b0, 1'b0, 1'b1, 9'h0AA, 16'hA1, 2'd1, 1'b1, 8'd0);
    tbl[8]  = mk(1'b0, 1'b1, 9'h055, 16'hB2, 1'b0, 1'b0, 1'b1, 9'h0AA, 16'hA1, 2'd2, 1'b0, 8'd1);
    tbl[9]  = mk(1'b0, 1'b0, 9'h000, 16'h00, 1'b0, 1'b0, 1'b1, 9'h0AA, 16'hA1, 2'd2, 1'b0, 8'd2);
    tbl[10] = mk(1'b0, 1'b0, 9'h000, 16'h00, 1'b1, 1'b0, 1'b1, 9'h055, 16'hB2, 2'd1, 1'b1, 8'd2);
    tbl[11] = mk(1'b0, 1'b0, 9'h000, 16'h00, 1'b1, 1'b0, 1'b0, 9'h000, 16'hB2, 2'd0, 1'b1, 8'd2);
    tbl[12] = mk(1'b0, 1'b1, 9'h0F0, 16'hD4, 1'b0, 1'b0, 1'b1, 9'h0F0, 16'hD4, 2'd1, 1'b1, 8'd2);
    tbl[13] = mk(1'b0, 1'b1, 9'h00F, 16'hE5, 1'b0, 1'b0, 1'b1, 9'h0F0, 16'hD4, 2'd2, 1'b0, 8'd3);
    tbl[14] = mk(1'b0, 1'b1, 9'h1FF, 16'hC3, 1'b0, 1'b1, 1'b0, 9'h000, 16'hD4, 2'd0, 1'b1, 8'd4);
    tbl[15] = mk(1'b0, 1'b0, 9'h000, 16'h00, 1'b1, 1'b0, 1'b0, 9'h000, 16'hD4, 2'd0, 1'b1, 8'd4);
    tbl[16] = mk(1'b0, 1'b1, 9'h1FF, 16'hC3, 1'b1, 1'b1, 1'b0, 9'h000, 16'hD4, 2'd0, 1'b1, 8'd4);
    tbl[17] = mk(1'b0, 1'b0, 9'h000, 16'h00, 1'b1, 1'b0, 1'b0, 9'h000, 16'hD4, 2'd0, 1'b1, 8'd4);
    tbl[18] = mk(1'b0, 1'b1, 9'h111, 16'h11, 1'b0, 1'b0, 1'b1, 9'h111, 16'h11, 2'd1, 1'b1, 8'd4);
    tbl[19] = mk(1'b0, 1'b1, 9'h122, 16'h22, 1'b0, 1'b0, 1'b1, 9'h111, 16'h11, 2'd2, 1'b0, 8'd5);
    tbl[20] = mk(1'b1, 1'b1, 9'h1FF, 16'hC3, 1'b0, 1'b1, 1'b0, 9'h000, 16'h00, 2'd0, 1'b1, 8'd0);
    tbl[21] = mk(1'b0, 1'b1, 9'h033, 16'h33, 1'b1, 1'b0, 1'b1, 9'h033, 16'h33, 2'd1, 1'b1, 8'd0);

    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].c, mkops(tbl[i].rd), tbl[i].ordy, tbl[i].fl);
      chk($sformatf("vec%0d_out_valid", i), {127'h0, out_valid}, {127'h0, tbl[i].ev});
      chk($sformatf("vec%0d_out_ctrl", i), {119'h0, out_ctrl}, {119'h0, tbl[i].ec});
      chk($sformatf("vec%0d_rd", i), {112'h0, out_ops[111:96]}, {112'h0, tbl[i].erd});
      chk($sformatf("vec%0d_occupancy", i), {126'h0, occupancy}, {126'h0, tbl[i].eocc});
      chk($sformatf("vec%0d_in_ready", i), {127'h0, in_ready}, {127'h0, tbl[i].eir});
      chk($sformatf("vec%0d_stall", i), {120'h0, stall_cnt}, {120'h0, tbl[i].est});
    end

    // Saturation: one entry held with out_ready low for 20 cycles, then 3 more
    drive(1'b1, 1'b0, 9'h000, '0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 9'h0AB, mkops(16'h005A), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 9'h000, '0, 1'b0, 1'b0);
    chk("sat_stall4_at20", {124'h0, d4_stall_cnt}, 128'd15);
    chk("sat_stall8_at20", {120'h0, stall_cnt}, 128'd20);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 9'h000, '0, 1'b0, 1'b0);
    chk("sat_stall4_hold", {124'h0, d4_stall_cnt}, 128'd15);
    chk("sat_stall8_at23", {120'h0, stall_cnt}, 128'd23);
    chk("sat_out_ctrl", {119'h0, out_ctrl}, 128'h0AB);
    drive(1'b1, 1'b0, 9'h000, '0, 1'b0, 1'b0);
    chk("sat_reset_stall4", {124'h0, d4_stall_cnt}, 128'd0);
    chk("sat_reset_out_ops", {16'h0, out_ops}, 128'd0);
    chk("sat_reset_out_valid", {127'h0, out_valid}, 128'd0);

    // Randomized traffic against the queue model
    drive(1'b1, 1'b0, 9'h000, '0, 1'b0, 1'b0);
    model_check();
    for (int i = 0; i < 600; i++) begin
      logic [127:0] r;
      logic         rs, vv, rd, fl;
      r  = {$urandom, $urandom, $urandom, $urandom};
      rs = ($urandom_range(0, 99) == 0);
      fl = ($urandom_range(0, 24) == 0);
      vv = ($urandom_range(0, 3) != 0);
      rd = (i % 100 < 30) ? 1'b0 : ($urandom_range(0, 2) != 0);
      drive(rs, vv, 9'($urandom), r[OW-1:0], rd, fl);
      model_check();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
